// File: rtl/spi_pkg.sv
// Shared SPI master types: FSM state, SPI mode pair and chip-select width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick counter: loads clk_div on load, then ticks once every clk_div+1 enabled cycles.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = clk_div;
      cnt_d = clk_div;
    end else if (tick) begin
      cnt_d = div_q;
    end else if (en) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with multiple chip selects, runtime mode and clock divider.
// Optional LSB-first ordering is enabled with macro SPI_MASTER_LSB_FIRST_EN.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic [cs_width(NUM_CS)-1:0] cs_sel,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic [DIV_W-1:0]            clk_div,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        sck,
  output logic                        mosi,
  input  logic                        miso,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic                        lsb_first,
`endif
  output logic [NUM_CS-1:0]           cs_n
);

  localparam int CSW    = cs_width(NUM_CS);
  localparam int EDGE_W = $clog2(2 * DATA_W);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              lsb_in, lsb_q;
  logic              accept, tick, lead;

  assign accept = (state_q == ST_IDLE) && start;
  assign lead   = ~edge_q[0];

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic lsb_d;
  assign lsb_in = lsb_first;
  always_comb lsb_d = accept ? lsb_first : lsb_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lsb_q <= 1'b0;
    else        lsb_q <= lsb_d;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .en      (state_q != ST_IDLE),
    .clk_div (clk_div),
    .tick    (tick)
  );

  function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    edge_d    = edge_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    done_d    = 1'b0;
    rx_data_d = rx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        sck_d = cpol;
        if (start) begin
          state_d     = ST_SETUP;
          mode_d.cpol = cpol;
          mode_d.cpha = cpha;
          edge_d      = '0;
          rx_sh_d     = '0;
          tx_sh_d     = tx_data;
          // cpha=0 needs the first bit on the wire before the first sck edge
          if (!cpha) begin
            mosi_d  = out_bit(tx_data, lsb_in);
            tx_sh_d = shift_out(tx_data, lsb_in);
          end
          for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_n_d[i] = (cs_sel != CSW'(i));
          end
        end
      end
      ST_SETUP: begin
        sck_d = mode_q.cpol;
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sck_d  = ~sck_q;
          edge_d = edge_q + EDGE_W'(1);
          if (lead ^ mode_q.cpha) begin
            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
          end else begin
            mosi_d  = out_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
          if (edge_q == EDGE_W'(2 * DATA_W - 1)) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        sck_d = mode_q.cpol;
        if (tick) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          cs_n_d    = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      edge_q    <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      done_q    <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      edge_q    <= edge_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed self-checking bench for spi_master_multi (NUM_CS=2 and NUM_CS=3 instances).
module tb_spi_master_multi;

  logic       clock, reset, start, start3;
  logic [7:0] tx_data, clk_div;
  logic       cs_sel;
  logic [1:0] cs_sel3;
  logic       cpol, cpha;
  logic       busy, done, sck, mosi, miso;
  logic [7:0] rx_data;
  logic [1:0] cs_n;
  logic       busy3, done3, sck3, mosi3;
  logic [7:0] rx3;
  logic [2:0] cs_n3;
  logic       loop_mode, slave_en, slave_miso;
  logic [7:0] slave_tx, slave_rx;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic       lsb_first;
`endif

  int tests_run;
  int tests_failed;

  assign miso = loop_mode ? mosi : slave_miso;

  spi_master_multi #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) u_dut (
    .clock(clock), .reset(reset), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .busy(busy), .done(done),
    .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs_n)
  );

  spi_master_multi #(.DATA_W(8), .NUM_CS(3), .DIV_W(8)) u_dut3 (
    .clock(clock), .reset(reset), .start(start3), .tx_data(tx_data), .cs_sel(cs_sel3),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .busy(busy3), .done(done3),
    .rx_data(rx3), .sck(sck3), .mosi(mosi3), .miso(mosi3),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .cs_n(cs_n3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Mode-3 slave: changes miso on falling sck, captures mosi on rising sck.
  always @(negedge sck) if (slave_en) begin
    slave_miso = slave_tx[7];
    slave_tx   = {slave_tx[6:0], 1'b0};
  end
  always @(posedge sck) if (slave_en) slave_rx = {slave_rx[6:0], mosi};

  task automatic kick(input logic [7:0] tx, input logic sel, input logic pol,
                      input logic pha, input logic [7:0] div);
    tx_data = tx; cs_sel = sel; cpol = pol; cpha = pha; clk_div = div; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Observes the main instance for a number of cycles; cycle 1 is the one after the accepting edge.
  task automatic measure(input int cycles, input int inject_cyc, output int done_cyc,
                         output int ndone, output int ntog, output int idle_cyc,
                         output logic [7:0] seq, output logic [1:0] cs_and, output logic [1:0] cs_or);
    logic prev, lead;
    done_cyc = 0; ndone = 0; ntog = 0; idle_cyc = 0; seq = '0; cs_and = '1; cs_or = '0;
    prev = sck;
    for (int c = 1; c <= cycles; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy !== 1'b1 && done_cyc == 0) idle_cyc++;
      if (busy === 1'b1) begin cs_and &= cs_n; cs_or |= cs_n; end
      if (sck !== prev) begin
        ntog++;
        lead = (sck !== cpol);
        if (lead != cpha) seq = {seq[6:0], mosi};
        prev = sck;
      end
      if (c == inject_cyc) begin start = 1'b1; tx_data = 8'hFF; end
      else start = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic run3(input int cycles, output int done_cyc, output int ntog,
                      output logic [2:0] cs_and, output logic [2:0] cs_or);
    logic prev;
    done_cyc = 0; ntog = 0; cs_and = '1; cs_or = '0; prev = sck3;
    for (int c = 1; c <= cycles; c++) begin
      if (done3 === 1'b1 && done_cyc == 0) done_cyc = c;
      if (busy3 === 1'b1) begin cs_and &= cs_n3; cs_or |= cs_n3; end
      if (sck3 !== prev) begin ntog++; prev = sck3; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cpol = 1'b1;
    @(negedge clock);
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++;
      $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", busy, done); end
    tests_run++; if (rx_data !== 8'h00 || sck !== 1'b0 || mosi !== 1'b0) begin tests_failed++;
      $display("FAIL reset_outputs: got rx=%h sck=%b mosi=%b expected 00 0 0", rx_data, sck, mosi); end
    tests_run++; if (cs_n !== 2'b11 || cs_n3 !== 3'b111) begin tests_failed++;
      $display("FAIL reset_cs_n: got %b/%b expected 11/111", cs_n, cs_n3); end
    reset = 1'b1;
    @(negedge clock);
    tests_run++; if (sck !== 1'b1) begin tests_failed++;
      $display("FAIL idle_sck_cpol1: got %b expected 1", sck); end
    cpol = 1'b0;
    @(negedge clock);
    tests_run++; if (sck !== 1'b0) begin tests_failed++;
      $display("FAIL idle_sck_cpol0: got %b expected 0", sck); end
  endtask

  task automatic test_mode0;
    int dc, nd, nt, ic; logic [7:0] sq; logic [1:0] ca, co;
    loop_mode = 1'b1;
    kick(8'hE9, 1'b0, 1'b0, 1'b0, 8'd1);
    tests_run++; if (busy !== 1'b1 || cs_n !== 2'b10) begin tests_failed++;
      $display("FAIL m0_first_cycle: got busy=%b cs_n=%b expected 1 10", busy, cs_n); end
    tests_run++; if (mosi !== 1'b1 || rx_data !== 8'h00) begin tests_failed++;
      $display("FAIL m0_setup_mosi: got mosi=%b rx=%h expected 1 00", mosi, rx_data); end
    measure(44, 0, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (dc !== 37 || nd !== 1) begin tests_failed++;
      $display("FAIL m0_done_timing: got cycle=%0d pulses=%0d expected 37 1", dc, nd); end
    tests_run++; if (rx_data !== 8'hE9 || sq !== 8'hE9) begin tests_failed++;
      $display("FAIL m0_data: got rx=%h wire=%h expected e9 e9", rx_data, sq); end
    tests_run++; if (nt !== 16 || ic !== 0 || ca !== 2'b10 || co !== 2'b10) begin tests_failed++;
      $display("FAIL m0_framing: got tog=%0d idle=%0d cs=%b/%b expected 16 0 10/10", nt, ic, ca, co); end
  endtask

  task automatic test_mode3;
    int dc, nd, nt, ic; logic [7:0] sq; logic [1:0] ca, co;
    cpol = 1'b1;
    @(negedge clock); @(negedge clock);
    tests_run++; if (sck !== 1'b1) begin tests_failed++;
      $display("FAIL m3_idle_high: got %b expected 1", sck); end
    loop_mode = 1'b0; slave_tx = 8'h5A; slave_rx = 8'h00; slave_miso = 1'b0; slave_en = 1'b1;
    kick(8'hA5, 1'b1, 1'b1, 1'b1, 8'd0);
    measure(24, 0, dc, nd, nt, ic, sq, ca, co);
    slave_en = 1'b0;
    tests_run++; if (rx_data !== 8'h5A || slave_rx !== 8'hA5) begin tests_failed++;
      $display("FAIL m3_data: got rx=%h slave=%h expected 5a a5", rx_data, slave_rx); end
    tests_run++; if (dc !== 19 || nd !== 1 || nt !== 16 || sck !== 1'b1) begin tests_failed++;
      $display("FAIL m3_timing: got done=%0d n=%0d tog=%0d sck=%b expected 19 1 16 1", dc, nd, nt, sck); end
    tests_run++; if (ca !== 2'b01 || co !== 2'b01 || sq !== 8'hA5) begin tests_failed++;
      $display("FAIL m3_cs_wire: got cs=%b/%b wire=%h expected 01/01 a5", ca, co, sq); end
    loop_mode = 1'b1; cpol = 1'b0;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_back_to_back;
    int dc, nd, nt, ic; logic [7:0] sq; logic [1:0] ca, co;
    kick(8'h3C, 1'b0, 1'b0, 1'b0, 8'd1);
    measure(80, 5, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (nd !== 1 || dc !== 37 || ic !== 0) begin tests_failed++;
      $display("FAIL busy_ignore: got pulses=%0d done=%0d idle=%0d expected 1 37 0", nd, dc, ic); end
    tests_run++; if (rx_data !== 8'h3C) begin tests_failed++;
      $display("FAIL busy_ignore_data: got %h expected 3c", rx_data); end
  endtask

  task automatic test_reset_abort;
    int dc, nd, nt, ic; logic [7:0] sq; logic [1:0] ca, co;
    kick(8'h96, 1'b0, 1'b0, 1'b0, 8'd1);
    measure(18, 0, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (nd !== 0 || busy !== 1'b1) begin tests_failed++;
      $display("FAIL abort_pre: got pulses=%0d busy=%b expected 0 1", nd, busy); end
    #2 reset = 1'b0;
    #1;
    tests_run++; if (cs_n !== 2'b11 || busy !== 1'b0 || done !== 1'b0 || sck !== 1'b0) begin tests_failed++;
      $display("FAIL abort_async: got cs=%b busy=%b done=%b sck=%b expected 11 0 0 0", cs_n, busy, done, sck); end
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    measure(5, 0, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (nd !== 0 || ic !== 5 || nt !== 0) begin tests_failed++;
      $display("FAIL abort_post: got pulses=%0d idle=%0d tog=%0d expected 0 5 0", nd, ic, nt); end
    kick(8'h96, 1'b0, 1'b0, 1'b0, 8'd1);
    measure(44, 0, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (rx_data !== 8'h96 || dc !== 37 || sq !== 8'h96) begin tests_failed++;
      $display("FAIL abort_next: got rx=%h done=%0d wire=%h expected 96 37 96", rx_data, dc, sq); end
  endtask

  task automatic test_cs_range;
    int dc, nt; logic [2:0] ca, co;
    tx_data = 8'h5C; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; cs_sel3 = 2'd3; start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0;
    tests_run++; if (busy3 !== 1'b1) begin tests_failed++;
      $display("FAIL cs_oob_busy: got %b expected 1", busy3); end
    run3(24, dc, nt, ca, co);
    tests_run++; if (ca !== 3'b111 || co !== 3'b111 || nt !== 16) begin tests_failed++;
      $display("FAIL cs_oob: got cs=%b/%b tog=%0d expected 111/111 16", ca, co, nt); end
    tests_run++; if (dc !== 19 || rx3 !== 8'h5C) begin tests_failed++;
      $display("FAIL cs_oob_done: got done=%0d rx=%h expected 19 5c", dc, rx3); end
    tx_data = 8'hC3; cs_sel3 = 2'd2; start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0;
    run3(24, dc, nt, ca, co);
    tests_run++; if (ca !== 3'b011 || co !== 3'b011 || dc !== 19 || rx3 !== 8'hC3) begin tests_failed++;
      $display("FAIL cs_top: got cs=%b/%b done=%0d rx=%h expected 011/011 19 c3", ca, co, dc, rx3); end
  endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
  task automatic test_lsb_first;
    int dc, nd, nt, ic; logic [7:0] sq; logic [1:0] ca, co;
    lsb_first = 1'b1;
    kick(8'h01, 1'b0, 1'b0, 1'b0, 8'd1);
    lsb_first = 1'b0;
    measure(44, 0, dc, nd, nt, ic, sq, ca, co);
    tests_run++; if (sq !== 8'b1000_0000 || rx_data !== 8'h01 || dc !== 37) begin tests_failed++;
      $display("FAIL lsb_first: got wire=%b rx=%h done=%0d expected 10000000 01 37", sq, rx_data, dc); end
  endtask
`endif

  initial begin
    tests_run = 0; tests_failed = 0;
    start = 1'b0; start3 = 1'b0; tx_data = '0; clk_div = '0; cs_sel = 1'b0; cs_sel3 = '0;
    cpha = 1'b0; loop_mode = 1'b1; slave_en = 1'b0; slave_miso = 1'b0;
    slave_tx = '0; slave_rx = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = 1'b0;
`endif
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_reset_abort();
    test_cs_range();
`ifdef SPI_MASTER_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (range 4..32).
REQ-002 SHALL have parameter NUM_CS, default 2, meaning number of chip-select outputs (range 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider input.
REQ-004 SHALL have port clock  input  1  the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  transfer request, sampled on the rising edge of clock.
REQ-007 SHALL have port tx_data  input  DATA_W  word to transmit.
REQ-008 SHALL have port cs_sel  input  $clog2(NUM_CS) (min 1)  target slave index.
REQ-009 SHALL have port cpol, cpha  input  1 each  SPI mode bits.
REQ-010 SHALL have port clk_div  input  DIV_W  half-period H = clk_div+1 clock cycles.
REQ-011 SHALL have port busy  output  1  transfer in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rx_data  output  DATA_W  last received word.
REQ-014 SHALL have ports sck, mosi (output, 1 each), miso (input, 1) and cs_n (output, NUM_CS, active-low).

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER and HOLD; IDLE->SETUP on an accepted start; SETUP->XFER after H cycles; XFER->HOLD after 2*DATA_W sck edges; HOLD->IDLE after H cycles.
REQ-016 SHALL accept start only when busy=0, latching tx_data, cs_sel, cpol, cpha and clk_div; start while busy=1 SHALL be ignored.
REQ-017 SHALL drive busy=1 from the cycle after acceptance until returning to IDLE.
REQ-018 SHALL make done=1 for exactly one cycle, in the first IDLE cycle, which is (2*DATA_W+2)*H+1 cycles after the accepting edge; busy=0 in that cycle and a start then SHALL be accepted.
REQ-019 SHALL hold sck at cpol in IDLE, SETUP and HOLD, toggling every H cycles in XFER.
REQ-020 With cpha=0, SHALL present the first mosi bit in SETUP, sample miso on leading edges and shift on trailing edges.
REQ-021 With cpha=1, SHALL shift mosi on leading edges and sample miso on trailing edges.
REQ-022 SHALL transmit MSB-first unless REQ-030 applies.
REQ-023 SHALL drive cs_n[cs_sel] low in SETUP, XFER and HOLD, and all other cs_n bits high; with cs_sel>=NUM_CS, all cs_n SHALL stay high while the transfer still runs.
REQ-024 SHALL update rx_data only in the done cycle; otherwise it SHALL hold its value.
REQ-025 With clk_div=0 (H=1), SHALL toggle sck every clock cycle with no lost bits.

Reset
REQ-026 While reset=0, SHALL force state IDLE, busy=0, done=0, rx_data=0, sck=0, mosi=0 and all cs_n=1, asynchronously.
REQ-027 Reset asserted mid-transfer SHALL abort without a done pulse; the first cycle after release SHALL be IDLE.
REQ-028 After reset release, sck SHALL take the value of the cpol input while in IDLE.

Configuration
REQ-029 SHALL compile macro SPI_MASTER_LSB_FIRST_EN.
REQ-030 With SPI_MASTER_LSB_FIRST_EN defined, SHALL add input port lsb_first (1 bit, latched with start); lsb_first=1 SHALL shift tx and rx LSB-first.
REQ-031 Without SPI_MASTER_LSB_FIRST_EN, port lsb_first SHALL not exist and order SHALL always be MSB-first.

Structure
REQ-032 SHALL place the state enum type and the SPI mode typedef (cpol/cpha pair) in shared package spi_pkg.
REQ-033 SHALL instantiate sub-module spi_clk_gen, a half-period tick counter (load clk_div, tick every H cycles, enable in SETUP/XFER/HOLD).

Verification
REQ-034 DATA_W=8, mode 0, clk_div=1, miso looped to mosi, tx 0xE9 -> rx_data=0xE9, done exactly 37 cycles after start, cs_n=2'b10 for cs_sel=0.
REQ-035 Mode 3 (cpol=1, cpha=1), clk_div=0, miso driven from a slave model shifting 0x5A, tx 0xA5 -> slave receives 0xA5, rx_data=0x5A, sck idle high.
REQ-036 A second start pulse 5 cycles after the first -> ignored, single done, busy continuous.
REQ-037 reset=0 at bit 4 of a transfer -> cs_n=all 1 and busy=0 immediately, no done, next transfer correct.
REQ-038 cs_sel=3 with NUM_CS=3 -> cs_n stays 3'b111 with sck toggling 16 times and done asserted.
REQ-039 SPI_MASTER_LSB_FIRST_EN, lsb_first=1, tx 0x01, loopback -> mosi high on first bit only, rx_data=0x01.
